// File: rtl/restart_monitor.sv
// Restart sequencer downstream of the alarm module: edge-detects restart/alarm inputs,
// generates the GOJAM pulse, and keeps the sticky cause register, lamp latch and restart count.
module restart_monitor #(
    parameter int unsigned GOJAM_CYCLES   = 8,
    parameter int unsigned HOLDOFF_CYCLES = 4,
    parameter int unsigned CNT_W          = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             RESTRT,
    input  logic             MSTRT,
    input  logic [7:0]       ALMIN,
    input  logic             RCH77,
    input  logic             WCH77,
    input  logic             ERRST,
    output logic             GOJAM,
    output logic             RSTLMP,
    output logic [7:0]       CH77,
    output logic             CH77V,
    output logic [CNT_W-1:0] RSTCNT,
    output logic             BUSY
);

    typedef enum logic [1:0] {StIdle, StJam, StHold} state_e;

    localparam logic [7:0]       JamLast  = 8'(GOJAM_CYCLES - 1);
    localparam logic [7:0]       HoldLast = 8'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    state_e     state_q;
    logic [7:0] timer_q;
    logic       restrt_q, mstrt_q, start_q;
    logic [7:0] almin_q, cause_q;
    logic [7:0] alm_rise;
    logic       restart_rise;

    assign alm_rise     = ALMIN & ~almin_q;
    assign restart_rise = (RESTRT & ~restrt_q) | (MSTRT & ~mstrt_q);

    // Input edge registers, sticky cause register and channel-77 read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            restrt_q <= 1'b0;
            mstrt_q  <= 1'b0;
            almin_q  <= 8'h00;
            start_q  <= 1'b0;
            cause_q  <= 8'h00;
            CH77     <= 8'h00;
            CH77V    <= 1'b0;
        end else begin
            restrt_q <= RESTRT;
            mstrt_q  <= MSTRT;
            almin_q  <= ALMIN;
            // Edges seen outside IDLE are dropped rather than queued.
            start_q  <= restart_rise & (state_q == StIdle);
            cause_q  <= (WCH77 ? 8'h00 : cause_q) | alm_rise;
            CH77V    <= RCH77;
            if (RCH77) begin
                CH77 <= cause_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            timer_q <= 8'h00;
            GOJAM   <= 1'b0;
            BUSY    <= 1'b0;
            RSTLMP  <= 1'b0;
            RSTCNT  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_q) begin
                        state_q <= StJam;
                        timer_q <= 8'h00;
                        GOJAM   <= 1'b1;
                        BUSY    <= 1'b1;
                    end
                end
                StJam: begin
                    if (timer_q == JamLast) begin
                        state_q <= StHold;
                        timer_q <= 8'h00;
                        GOJAM   <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                StHold: begin
                    if (timer_q == HoldLast) begin
                        state_q <= StIdle;
                        timer_q <= 8'h00;
                        BUSY    <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    timer_q <= 8'h00;
                    GOJAM   <= 1'b0;
                    BUSY    <= 1'b0;
                end
            endcase

            // Entering JAM sets the lamp even if ERRST is held that cycle.
            if (state_q == StIdle && start_q) begin
                RSTLMP <= 1'b1;
                if (RSTCNT != CntMax) begin
                    RSTCNT <= RSTCNT + CNT_W'(1);
                end
            end else if (ERRST) begin
                RSTLMP <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_restart_monitor.sv
// Directed bench for restart_monitor: an event-timeline model checked every cycle,
// plus hand-computed literal checks at the key points of each scenario.
module tb_restart_monitor;

    localparam int G       = 8;
    localparam int H       = 4;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          RESTRT = 1'b0, MSTRT = 1'b0, RCH77 = 1'b0, WCH77 = 1'b0, ERRST = 1'b0;
    logic [7:0]    ALMIN = 8'h00;
    logic          GOJAM, RSTLMP, CH77V, BUSY;
    logic [7:0]    CH77;
    logic [CW-1:0] RSTCNT;

    int nvec  = 0;
    int nfail = 0;

    restart_monitor #(
        .GOJAM_CYCLES  (G),
        .HOLDOFF_CYCLES(H),
        .CNT_W         (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RESTRT(RESTRT),
        .MSTRT (MSTRT),
        .ALMIN (ALMIN),
        .RCH77 (RCH77),
        .WCH77 (WCH77),
        .ERRST (ERRST),
        .GOJAM (GOJAM),
        .RSTLMP(RSTLMP),
        .CH77  (CH77),
        .CH77V (CH77V),
        .RSTCNT(RSTCNT),
        .BUSY  (BUSY)
    );

    initial forever #5 clk = ~clk;

    // Model: a restart is a scheduled window [jam_start, jam_start+G+H) in cycle numbers.
    int         cyc       = 0;
    int         jam_start = -100;
    int         idle_from = 0;
    int         m_cnt     = 0;
    logic       m_lamp    = 1'b0;
    logic       m_ch77v   = 1'b0;
    logic [7:0] m_cause   = 8'h00;
    logic [7:0] m_ch77    = 8'h00;
    logic [7:0] p_alm     = 8'h00;
    logic       p_r       = 1'b0;
    logic       p_m       = 1'b0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            cyc = 0; jam_start = -100; idle_from = 0; m_cnt = 0; m_lamp = 1'b0;
            m_ch77v = 1'b0; m_cause = 8'h00; m_ch77 = 8'h00; p_alm = 8'h00;
            p_r = 1'b0; p_m = 1'b0;
        end else begin
            if (cyc == jam_start - 1) begin
                m_lamp = 1'b1;
                if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            end else if (ERRST) begin
                m_lamp = 1'b0;
            end
            if (((RESTRT && !p_r) || (MSTRT && !p_m)) && cyc >= idle_from) begin
                jam_start = cyc + 2;
                idle_from = cyc + 2 + G + H;
            end
            m_ch77v = RCH77;
            if (RCH77) m_ch77 = m_cause;
            m_cause = (WCH77 ? 8'h00 : m_cause) | (ALMIN & ~p_alm);
            p_alm = ALMIN; p_r = RESTRT; p_m = MSTRT;
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        chk("gojam", int'(GOJAM), int'(cyc >= jam_start && cyc < jam_start + G));
        chk("busy", int'(BUSY), int'(cyc >= jam_start && cyc < jam_start + G + H));
        chk("rstlmp", int'(RSTLMP), int'(m_lamp));
        chk("rstcnt", int'(RSTCNT), m_cnt);
        chk("ch77", int'(CH77), int'(m_ch77));
        chk("ch77v", int'(CH77V), int'(m_ch77v));
    end

    task automatic goto(input int n);
        int guard = 0;
        while (cyc < n && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc != n) begin
            nfail++;
            $display("FAIL goto: reached cycle %0d, wanted %0d", cyc, n);
        end
    endtask

    initial begin
        #100000;
        nfail++;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("lit_rst_gojam", int'(GOJAM), 0);
        chk("lit_rst_busy", int'(BUSY), 0);
        chk("lit_rst_cnt", int'(RSTCNT), 0);
        chk("lit_rst_ch77", int'(CH77), 0);
        rst_n = 1'b1;

        // First restart: GOJAM 12..19, BUSY 12..23; RESTRT held high must not retrigger.
        goto(10); RESTRT = 1'b1;
        goto(11); chk("lit_gojam_c11", int'(GOJAM), 0);
        goto(12); chk("lit_gojam_c12", int'(GOJAM), 1);
        chk("lit_busy_c12", int'(BUSY), 1);
        chk("lit_cnt_c12", int'(RSTCNT), 1);
        chk("lit_lamp_c12", int'(RSTLMP), 1);
        goto(19); chk("lit_gojam_c19", int'(GOJAM), 1);
        goto(20); chk("lit_gojam_c20", int'(GOJAM), 0);
        chk("lit_busy_c20", int'(BUSY), 1);
        goto(23); chk("lit_busy_c23", int'(BUSY), 1);
        goto(24); chk("lit_busy_c24", int'(BUSY), 0);
        goto(26); RESTRT = 1'b0;
        chk("lit_noretrig", int'(BUSY), 0);

        // Cause latching and reads.
        goto(27); ALMIN = 8'h01;
        goto(29); ALMIN = 8'h09;
        goto(31); RCH77 = 1'b1;
        goto(32); RCH77 = 1'b0;
        chk("lit_ch77_09", int'(CH77), 8'h09);
        chk("lit_ch77v", int'(CH77V), 1);
        goto(33); chk("lit_ch77v_drop", int'(CH77V), 0);
        goto(34); WCH77 = 1'b1;
        goto(35); WCH77 = 1'b0; RCH77 = 1'b1;
        goto(36); RCH77 = 1'b0;
        chk("lit_ch77_clr", int'(CH77), 8'h00);
        goto(37); ALMIN = 8'h00;
        goto(38); ALMIN = 8'h81;
        goto(39); RCH77 = 1'b1;
        goto(40); RCH77 = 1'b0;
        chk("lit_ch77_81", int'(CH77), 8'h81);
        ALMIN = 8'h91; WCH77 = 1'b1;
        goto(41); WCH77 = 1'b0; RCH77 = 1'b1;
        goto(42); RCH77 = 1'b0;
        chk("lit_set_wins", int'(CH77), 8'h10);
        goto(43); RCH77 = 1'b1; WCH77 = 1'b1;
        goto(44); WCH77 = 1'b0;
        chk("lit_read_preclear", int'(CH77), 8'h10);
        goto(45); RCH77 = 1'b0;
        chk("lit_read_postclear", int'(CH77), 8'h00);

        // Edge during HOLD is dropped; edge one cycle into IDLE restarts.
        goto(50); RESTRT = 1'b1;
        goto(51); RESTRT = 1'b0;
        goto(61); RESTRT = 1'b1;
        chk("lit_hold_busy", int'(BUSY), 1);
        goto(62); RESTRT = 1'b0;
        goto(65); chk("lit_hold_drop_busy", int'(BUSY), 0);
        chk("lit_hold_drop_cnt", int'(RSTCNT), 2);
        RESTRT = 1'b1;
        goto(66); RESTRT = 1'b0;
        goto(67); chk("lit_re_gojam", int'(GOJAM), 1);
        chk("lit_re_cnt", int'(RSTCNT), 3);
        goto(75); chk("lit_re_gojam_end", int'(GOJAM), 0);

        // Saturation: 14 manual restarts bring the total to 17.
        goto(79);
        for (int i = 0; i < 14; i++) begin
            MSTRT = 1'b1;
            @(posedge clk); #1;
            MSTRT = 1'b0;
            repeat (13) begin @(posedge clk); #1; end
        end
        chk("lit_sat_cnt", int'(RSTCNT), 15);
        chk("lit_sat_lamp", int'(RSTLMP), 1);

        // Lamp clear in idle, then set-wins with ERRST held through entry.
        ERRST = 1'b1;
        goto(276); ERRST = 1'b0;
        chk("lit_lamp_clr", int'(RSTLMP), 0);
        goto(278); ERRST = 1'b1; RESTRT = 1'b1;
        goto(279); RESTRT = 1'b0;
        chk("lit_lamp_pre", int'(RSTLMP), 0);
        goto(280); chk("lit_lamp_setwins", int'(RSTLMP), 1);
        ERRST = 1'b0;
        goto(281); chk("lit_lamp_hold", int'(RSTLMP), 1);
        ALMIN = 8'h00;
        goto(282); ALMIN = 8'h40;
        goto(283); RCH77 = 1'b1;
        goto(284); RCH77 = 1'b0;
        chk("lit_ch77_40", int'(CH77), 8'h40);

        // Asynchronous reset in the 3rd GOJAM cycle.
        goto(292); MSTRT = 1'b1;
        goto(293); MSTRT = 1'b0;
        goto(296); chk("lit_jam3", int'(GOJAM), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("lit_async_gojam", int'(GOJAM), 0);
        chk("lit_async_lamp", int'(RSTLMP), 0);
        chk("lit_async_cnt", int'(RSTCNT), 0);
        chk("lit_async_ch77", int'(CH77), 0);
        chk("lit_async_busy", int'(BUSY), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        goto(3); RCH77 = 1'b1;
        goto(4); RCH77 = 1'b0;
        chk("lit_post_rst_gojam", int'(GOJAM), 0);
        goto(8);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
